// File: rtl/output_event_capture_if.sv
// Event stream interface for output_event_capture.
// Carries the FIFO head event to a consumer with a valid/ready handshake.
//   evt_valid : producer -> consumer, the head entry holds an event
//   evt_ready : consumer -> producer, the head event is taken on this edge
//   evt_data  : producer -> consumer, {prev_code[2:0], new_code[2:0], timestamp}
interface output_event_capture_if #(
  parameter int TS_WIDTH = 8
);
  logic                  evt_valid;
  logic                  evt_ready;
  logic [TS_WIDTH+5:0]   evt_data;

  modport master (output evt_valid, output evt_data, input evt_ready);
  modport slave  (input evt_valid, input evt_data, output evt_ready);
endinterface

// File: rtl/output_event_capture.sv
// Output event capture.
// Synchronizes a 3-bit output code from an asynchronous logic stage, accepts a
// new code only after it has been held for STABLE_CYCLES consecutive samples,
// and logs each accepted change as {old code, new code, timestamp} in a small
// FIFO drained through a valid/ready interface.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   in_vec        : raw 3-bit code, asynchronous to clk
//   en            : capture enable
//   evt           : event stream (master side)
//   stable_code   : currently accepted code
//   overflow      : sticky flag, an event was dropped on a full FIFO
//   clr_overflow  : synchronous clear of overflow and drop_count
//   drop_count    : saturating count of dropped events
module output_event_capture #(
  parameter int STABLE_CYCLES = 4,
  parameter int FIFO_DEPTH    = 4,
  parameter int TS_WIDTH      = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [2:0]                    in_vec,
  input  logic                          en,
  output_event_capture_if.master        evt,
  output logic [2:0]                    stable_code,
  output logic                          overflow,
  input  logic                          clr_overflow,
  output logic [7:0]                    drop_count
);

  localparam int DW = 6 + TS_WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);
  // Count value that, when incremented on a matching sample, completes qualification.
  localparam logic [7:0] QLAST = 8'(STABLE_CYCLES - 1);

  typedef enum logic {IDLE, QUALIFY} state_t;

  logic [2:0]          sync1_q, sync1_d;
  logic [2:0]          sync_code_q, sync_code_d;
  state_t              state_q, state_d;
  logic [2:0]          candidate_q, candidate_d;
  logic [7:0]          qcnt_q, qcnt_d;
  logic [2:0]          stable_q, stable_d;
  logic [TS_WIDTH-1:0] ts_q, ts_d;
  logic [DW-1:0]       mem_q [FIFO_DEPTH];
  logic [DW-1:0]       mem_d [FIFO_DEPTH];
  logic [AW:0]         wr_ptr_q, wr_ptr_d;
  logic [AW:0]         rd_ptr_q, rd_ptr_d;
  logic                overflow_q, overflow_d;
  logic [7:0]          drop_q, drop_d;

  logic commit, pop, push, drop, empty, full;

  // Extra pointer bit separates full (MSBs differ) from empty (pointers equal).
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  always_comb begin
    sync1_d     = in_vec;
    sync_code_d = sync1_q;
    state_d     = state_q;
    candidate_d = candidate_q;
    qcnt_d      = qcnt_q;
    stable_d    = stable_q;
    ts_d        = ts_q + 1'b1;
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    overflow_d  = overflow_q;
    drop_d      = drop_q;
    commit      = 1'b0;

    // Qualification: a differing code must repeat on consecutive samples; a
    // return to the accepted code cancels it, a third code restarts it.
    if (!en) begin
      state_d = IDLE;
      qcnt_d  = 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (sync_code_q != stable_q) begin
            state_d     = QUALIFY;
            candidate_d = sync_code_q;
            qcnt_d      = 8'd1;
          end
        end
        QUALIFY: begin
          if (sync_code_q == candidate_q) begin
            if (qcnt_q == QLAST) begin
              commit   = 1'b1;
              state_d  = IDLE;
              qcnt_d   = 8'd0;
              stable_d = candidate_q;
            end else begin
              qcnt_d = qcnt_q + 8'd1;
            end
          end else if (sync_code_q == stable_q) begin
            state_d = IDLE;
            qcnt_d  = 8'd0;
          end else begin
            candidate_d = sync_code_q;
            qcnt_d      = 8'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // A pop frees a slot on the same edge, so a full FIFO still accepts a push.
    pop  = !empty && evt.evt_ready;
    push = commit && (!full || pop);
    drop = commit && full && !pop;

    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push) begin
      mem_d[wr_ptr_q[AW-1:0]] = {stable_q, candidate_q, ts_q};
      wr_ptr_d                = wr_ptr_q + 1'b1;
    end

    // A drop on the clearing edge takes priority and restarts the count at 1.
    if (drop) begin
      overflow_d = 1'b1;
      if (clr_overflow) begin
        drop_d = 8'd1;
      end else if (drop_q != 8'hFF) begin
        drop_d = drop_q + 8'd1;
      end
    end else if (clr_overflow) begin
      overflow_d = 1'b0;
      drop_d     = 8'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= '0;
      sync_code_q <= '0;
      state_q     <= IDLE;
      candidate_q <= '0;
      qcnt_q      <= '0;
      stable_q    <= '0;
      ts_q        <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      drop_q      <= '0;
    end else begin
      sync1_q     <= sync1_d;
      sync_code_q <= sync_code_d;
      state_q     <= state_d;
      candidate_q <= candidate_d;
      qcnt_q      <= qcnt_d;
      stable_q    <= stable_d;
      ts_q        <= ts_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= overflow_d;
      drop_q      <= drop_d;
    end
  end

  // Data is forced to zero when nothing is buffered.
  assign evt.evt_valid = !empty;
  assign evt.evt_data  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign stable_code   = stable_q;
  assign overflow      = overflow_q;
  assign drop_count    = drop_q;

endmodule
